// File: rtl/sm_config.sv
// Shared configuration for the sm_* peripherals: pin count and register offsets
// of the GPIO interrupt block.
package sm_config;

    localparam int GPIO_WIDTH = 8;

    localparam logic [3:0] GPIO_IRQ_REG_PEND   = 4'h0;
    localparam logic [3:0] GPIO_IRQ_REG_ENABLE = 4'h4;
    localparam logic [3:0] GPIO_IRQ_REG_RISE   = 4'h8;
    localparam logic [3:0] GPIO_IRQ_REG_FALL   = 4'hC;

endpackage

// File: rtl/sm_gpio_edge.sv
// Per-pin edge detector: previous-sample register, primed flag and the
// rising/falling event terms qualified by enable.
module sm_gpio_edge #(
    parameter int SIZE = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [SIZE-1:0] pins,
    input  logic [SIZE-1:0] riseSel,
    input  logic [SIZE-1:0] fallSel,
    input  logic [SIZE-1:0] enable,
    output logic [SIZE-1:0] ev
);

    logic [SIZE-1:0] prevPins;
    logic            primed;
    logic [SIZE-1:0] riseEv;
    logic [SIZE-1:0] fallEv;

    // primed masks the first cycle so the pin state at reset release is never an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prevPins <= {SIZE{1'b0}};
            primed   <= 1'b0;
        end else begin
            prevPins <= pins;
            primed   <= 1'b1;
        end
    end

    // Event terms from the current pins against the previous sample.
    always_comb begin
        riseEv = pins & ~prevPins & riseSel;
        fallEv = ~pins & prevPins & fallSel;
        ev     = (riseEv | fallEv) & enable & {SIZE{primed}};
    end

endmodule

// File: rtl/sm_register_we.sv
// Plain write-enabled register with asynchronous active-low clear.
module sm_register_we #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Load d when we is high, otherwise hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= {WIDTH{1'b0}};
        end else if (we) begin
            q <= d;
        end else begin
            q <= q;
        end
    end

endmodule

// File: rtl/sm_gpio_irq.sv
// GPIO edge interrupt peripheral: latches enabled pin edges into W1C pending bits
// and drives a single level interrupt line.
module sm_gpio_irq
    import sm_config::*;
#(
    parameter int WIDTH = GPIO_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             bSel,
    input  logic [31:0]      bAddr,
    input  logic             bWrite,
    input  logic [31:0]      bWData,
    output logic [31:0]      bRData,
    input  logic [WIDTH-1:0] gpioIn,
    output logic             irq
);

    logic [3:0]       regAddr;
    logic             wrEn;
    logic             weEnable;
    logic             weRise;
    logic             weFall;
    logic [WIDTH-1:0] wData;
    logic [WIDTH-1:0] w1c;
    logic [WIDTH-1:0] pend;
    logic [WIDTH-1:0] enable;
    logic [WIDTH-1:0] riseSel;
    logic [WIDTH-1:0] fallSel;
    logic [WIDTH-1:0] ev;
    logic [31:0]      rdData;

    assign regAddr = bAddr[3:0];
    assign wrEn    = bSel & bWrite;
    assign wData   = bWData[WIDTH-1:0];

    generate
        if (WIDTH < 32) begin : gUnusedData
            logic unusedBits;
            assign unusedBits = ^{bAddr[31:4], bWData[31:WIDTH]};
        end else begin : gUnusedAddr
            logic unusedBits;
            assign unusedBits = ^bAddr[31:4];
        end
    endgenerate

    // Register write decode; W1C mask is zero unless PEND is written.
    always_comb begin
        weEnable = wrEn && (regAddr == GPIO_IRQ_REG_ENABLE);
        weRise   = wrEn && (regAddr == GPIO_IRQ_REG_RISE);
        weFall   = wrEn && (regAddr == GPIO_IRQ_REG_FALL);
        if (wrEn && (regAddr == GPIO_IRQ_REG_PEND)) begin
            w1c = wData;
        end else begin
            w1c = {WIDTH{1'b0}};
        end
    end

    sm_register_we #(.WIDTH(WIDTH)) uEnable (
        .clk(clk), .rst_n(rst_n), .we(weEnable), .d(wData), .q(enable)
    );

    sm_register_we #(.WIDTH(WIDTH)) uRise (
        .clk(clk), .rst_n(rst_n), .we(weRise), .d(wData), .q(riseSel)
    );

    sm_register_we #(.WIDTH(WIDTH)) uFall (
        .clk(clk), .rst_n(rst_n), .we(weFall), .d(wData), .q(fallSel)
    );

    sm_gpio_edge #(.SIZE(WIDTH)) uEdge (
        .clk     (clk),
        .rst_n   (rst_n),
        .pins    (gpioIn),
        .riseSel (riseSel),
        .fallSel (fallSel),
        .enable  (enable),
        .ev      (ev)
    );

    // Pending bits: new events are ORed in after the clear so a coincident event survives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend <= {WIDTH{1'b0}};
        end else begin
            pend <= (pend & ~w1c) | ev;
        end
    end

    // Read mux; unmapped offsets alias PEND, upper bits read zero.
    always_comb begin
        rdData = 32'h0000_0000;
        case (regAddr)
            GPIO_IRQ_REG_ENABLE: rdData[WIDTH-1:0] = enable;
            GPIO_IRQ_REG_RISE:   rdData[WIDTH-1:0] = riseSel;
            GPIO_IRQ_REG_FALL:   rdData[WIDTH-1:0] = fallSel;
            default:             rdData[WIDTH-1:0] = pend;
        endcase
    end

    assign bRData = rdData;
    assign irq    = |(pend & enable);

endmodule

// File: tb/tb_sm_gpio_irq.sv
// Directed scoreboard bench for sm_gpio_irq: stimulus queues expected read/irq
// values, an event-driven monitor pops and compares them.
`timescale 1ns/1ps
module tb_sm_gpio_irq;

    logic        clk;
    logic        rst_n;
    logic        bSel;
    logic [31:0] bAddr;
    logic        bWrite;
    logic [31:0] bWData;
    logic [31:0] bRData;
    logic [7:0]  gpioIn;
    logic        irq;

    typedef struct {
        string       name;
        logic [31:0] data;
        logic        irq;
    } exp_t;

    exp_t sb[$];
    event chk;
    int   vectors = 0;
    int   miscompares = 0;

    sm_gpio_irq #(.WIDTH(8)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bSel   (bSel),
        .bAddr  (bAddr),
        .bWrite (bWrite),
        .bWData (bWData),
        .bRData (bRData),
        .gpioIn (gpioIn),
        .irq    (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: compare every queued expectation when the stimulus presents a sample point.
    always @(chk) begin
        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            vectors++;
            if (bRData !== e.data || irq !== e.irq) begin
                miscompares++;
                $display("FAIL %s: got bRData=%h irq=%b, expected bRData=%h irq=%b",
                         e.name, bRData, irq, e.data, e.irq);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic busWrite(input logic [31:0] addr, input logic [31:0] data);
        bSel   = 1'b1;
        bWrite = 1'b1;
        bAddr  = addr;
        bWData = data;
        tick();
        bSel   = 1'b0;
        bWrite = 1'b0;
        bWData = 32'h0000_0000;
    endtask

    task automatic check(input string name, input logic [31:0] addr,
                         input logic [31:0] expData, input logic expIrq);
        exp_t e;
        bAddr = addr;
        #1;
        e.name = name;
        e.data = expData;
        e.irq  = expIrq;
        sb.push_back(e);
        ->chk;
        #1;
    endtask

    initial begin
        rst_n  = 1'b0;
        bSel   = 1'b0;
        bWrite = 1'b0;
        bAddr  = 32'h0;
        bWData = 32'h0;
        gpioIn = 8'hFF;
        #12;
        check("reset_pend", 32'h0, 32'h0, 1'b0);
        check("reset_enable", 32'h4, 32'h0, 1'b0);
        rst_n = 1'b1;
        tick();

        // 1: no spurious events from the reset-time pin state
        busWrite(32'h4, 32'hFF);
        busWrite(32'h8, 32'hFF);
        busWrite(32'hC, 32'hFF);
        tick(); tick(); tick();
        check("t1_pend_quiet", 32'h0, 32'h0, 1'b0);
        check("t1_rise_rd", 32'h8, 32'hFF, 1'b0);

        // 2: rising edge on pin0, latency and W1C
        busWrite(32'h4, 32'h01);
        busWrite(32'h8, 32'h01);
        busWrite(32'hC, 32'h00);
        gpioIn = 8'h00;
        tick(); tick();
        check("t2_fall_ignored", 32'h0, 32'h0, 1'b0);
        gpioIn = 8'h01;
        check("t2_before_edge", 32'h0, 32'h0, 1'b0);
        tick();
        check("t2_latched", 32'h0, 32'h01, 1'b1);
        busWrite(32'h0, 32'h01);
        check("t2_cleared", 32'h0, 32'h0, 1'b0);

        // 3: falling only on pin3, disabled pin2 edge dropped
        busWrite(32'h4, 32'h08);
        busWrite(32'h8, 32'h04);
        busWrite(32'hC, 32'h08);
        gpioIn = 8'h09;
        tick();
        check("t3_rise_pin3", 32'h0, 32'h0, 1'b0);
        gpioIn = 8'h01;
        tick();
        check("t3_fall_pin3", 32'h0, 32'h08, 1'b1);
        gpioIn = 8'h09;
        tick();
        check("t3_rise_again", 32'h0, 32'h08, 1'b1);
        gpioIn = 8'h0D;
        tick();
        check("t3_pin2_disabled", 32'h0, 32'h08, 1'b1);
        busWrite(32'h4, 32'h0C);
        check("t3_pin2_not_kept", 32'h0, 32'h08, 1'b1);
        busWrite(32'h0, 32'hFF);
        check("t3_clear_all", 32'h0, 32'h0, 1'b0);

        // 4: event and W1C on the same bit in the same cycle
        busWrite(32'h4, 32'h01);
        busWrite(32'h8, 32'h01);
        busWrite(32'hC, 32'h00);
        gpioIn = 8'h0C;
        tick();
        gpioIn = 8'h0D;
        tick();
        check("t4_set", 32'h0, 32'h01, 1'b1);
        gpioIn = 8'h0C;
        tick();
        gpioIn = 8'h0D;
        busWrite(32'h0, 32'h01);
        check("t4_event_wins", 32'h0, 32'h01, 1'b1);
        tick();
        check("t4_hold", 32'h0, 32'h01, 1'b1);

        // 5: masking keeps the pending bit
        busWrite(32'h0, 32'hFF);
        busWrite(32'h4, 32'h04);
        busWrite(32'h8, 32'h04);
        gpioIn = 8'h09;
        tick();
        gpioIn = 8'h0D;
        tick();
        check("t5_pend", 32'h0, 32'h04, 1'b1);
        busWrite(32'h4, 32'h00);
        check("t5_masked", 32'h0, 32'h04, 1'b0);
        check("t5_enable_rd", 32'h4, 32'h0, 1'b0);
        busWrite(32'h4, 32'hFFFF_FF04);
        check("t5_unmasked", 32'h0, 32'h04, 1'b1);
        check("t5_enable_upper", 32'h4, 32'h04, 1'b1);

        // bus corner cases: deselected write, unmapped offset, upper address bits
        bSel   = 1'b0;
        bWrite = 1'b1;
        bAddr  = 32'h0;
        bWData = 32'hFF;
        tick();
        bWrite = 1'b0;
        check("nosel_no_clear", 32'h0, 32'h04, 1'b1);
        busWrite(32'h2, 32'hFF);
        check("unmapped_rd", 32'h2, 32'h04, 1'b1);
        check("unmapped_no_wr", 32'h4, 32'h04, 1'b1);
        check("upper_addr_rd", 32'h108, 32'h04, 1'b1);

        // 6: asynchronous reset mid-cycle
        busWrite(32'h4, 32'hFF);
        busWrite(32'h8, 32'hFF);
        busWrite(32'hC, 32'h00);
        gpioIn = 8'h00;
        tick();
        gpioIn = 8'hFF;
        tick();
        check("t6_all_pend", 32'h0, 32'hFF, 1'b1);
        #1;
        rst_n = 1'b0;
        #1;
        check("t6_rst_pend", 32'h0, 32'h0, 1'b0);
        check("t6_rst_enable", 32'h4, 32'h0, 1'b0);
        check("t6_rst_rise", 32'h8, 32'h0, 1'b0);
        check("t6_rst_fall", 32'hC, 32'h0, 1'b0);
        tick();
        rst_n = 1'b1;
        tick(); tick();
        check("t6_after_rst", 32'h0, 32'h0, 1'b0);

        #2;
        if (sb.size() != 0) begin
            miscompares += sb.size();
            $display("FAIL scoreboard_drain: got %0d unchecked entries, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
